// File: rtl/add_result_stage.sv
// Result capture stage behind the carry-select adder: flags each sum, optionally
// saturates it on signed overflow, and buffers it in a 2-entry FIFO.
module add_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    input  logic             sat_en,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic [7:0]       ovf_cnt,
    output logic [15:0]      done_cnt
);

    function automatic logic detect_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Clamp toward the operands' sign: both negative -> most negative, else most positive.
    function automatic logic signed [WIDTH-1:0] saturate(
        input logic signed [WIDTH-1:0] raw,
        input logic                    ovf,
        input logic                    en,
        input logic                    a_msb
    );
        if (en && ovf)
            return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return raw;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic signed [WIDTH-1:0] sum_p0;
    logic                    ovf_p0;
    logic                    zero_p0;
    logic                    neg_p0;

    logic signed [WIDTH-1:0] sum_p1  [2];
    logic                    cout_p1 [2];
    logic                    zero_p1 [2];
    logic                    neg_p1  [2];
    logic                    ovf_p1  [2];

    logic [1:0] count_q;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push;
    logic       pop;

    // p0: flag and saturate the raw adder result
    always_comb begin
        ovf_p0  = detect_ovf(in_a_msb, in_b_msb, in_sum[WIDTH-1]);
        sum_p0  = saturate($signed(in_sum), ovf_p0, sat_en, in_a_msb);
        zero_p0 = (sum_p0 == '0);
        neg_p0  = sum_p0[WIDTH-1];
    end

    // rst_n gates in_ready so nothing is taken while reset is held.
    assign in_ready  = rst_n & (count_q != 2'd2) & ~flush;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~flush;

    // p1: two-entry storage
    always_ff @(posedge clk) begin
        if (push) begin
            sum_p1[wr_ptr]  <= sum_p0;
            cout_p1[wr_ptr] <= in_cout;
            zero_p1[wr_ptr] <= zero_p0;
            neg_p1[wr_ptr]  <= neg_p0;
            ovf_p1[wr_ptr]  <= ovf_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            ovf_cnt  <= 8'd0;
            done_cnt <= 16'd0;
        end else if (flush) begin
            count_q <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            if (push && ovf_p0)
                ovf_cnt <= sat_inc8(ovf_cnt);
            if (pop)
                done_cnt <= done_cnt + 16'd1;
        end
    end

    always_comb begin
        out_sum  = '0;
        out_cout = 1'b0;
        out_zero = 1'b0;
        out_neg  = 1'b0;
        out_ovf  = 1'b0;
        if (out_valid) begin
            out_sum  = sum_p1[rd_ptr];
            out_cout = cout_p1[rd_ptr];
            out_zero = zero_p1[rd_ptr];
            out_neg  = neg_p1[rd_ptr];
            out_ovf  = ovf_p1[rd_ptr];
        end
    end

endmodule

// File: tb/tb_add_result_stage.sv
// Bench for add_result_stage: directed scenarios plus random traffic checked
// against a queue model built from operand arithmetic.
module tb_add_result_stage;
    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        zero;
        logic        neg;
        logic        ovf;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_sum = '0;
    logic        in_cout = 1'b0;
    logic        in_a_msb = 1'b0;
    logic        in_b_msb = 1'b0;
    logic        sat_en = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_cout, out_zero, out_neg, out_ovf;
    logic [7:0]  ovf_cnt;
    logic [15:0] done_cnt;

    always #5 clk = ~clk;

    add_result_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
        .sat_en(sat_en), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_zero(out_zero), .out_neg(out_neg),
        .out_ovf(out_ovf), .ovf_cnt(ovf_cnt), .done_cnt(done_cnt)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    ent_t q[$];
    int   m_ovf = 0;
    int   m_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: true signed sum of the operands decides overflow and clamp.
    function automatic ent_t mk_entry(input logic [31:0] a, input logic [31:0] b, input bit sat);
        ent_t        e;
        longint      s;
        logic [32:0] u;
        s = longint'($signed(a)) + longint'($signed(b));
        u = {1'b0, a} + {1'b0, b};
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.cout = u[32];
        e.sum  = u[31:0];
        if (sat && e.ovf)
            e.sum = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        e.zero = (e.sum == 32'd0);
        e.neg  = e.sum[31];
        return e;
    endfunction

    task automatic check_outputs(input string ctx);
        ent_t h;
        h = '{sum: 32'd0, cout: 1'b0, zero: 1'b0, neg: 1'b0, ovf: 1'b0};
        if (q.size() > 0) h = q[0];
        chk({ctx, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({ctx, ".out_sum"},   out_sum, h.sum);
        chk({ctx, ".out_cout"},  32'(out_cout), 32'(h.cout));
        chk({ctx, ".out_zero"},  32'(out_zero), 32'(h.zero));
        chk({ctx, ".out_neg"},   32'(out_neg), 32'(h.neg));
        chk({ctx, ".out_ovf"},   32'(out_ovf), 32'(h.ovf));
        chk({ctx, ".ovf_cnt"},   32'(ovf_cnt), 32'(m_ovf));
        chk({ctx, ".done_cnt"},  32'(done_cnt), 32'(m_done & 16'hFFFF));
    endtask

    // One clock: drive at negedge, predict handshake, update model at posedge, check at next negedge.
    task automatic cycle(input string ctx, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input bit sat, input bit fl, input bit ordy);
        bit   m_ready, do_push, do_pop;
        ent_t e;
        logic [32:0] u;
        u         = {1'b0, a} + {1'b0, b};
        in_valid  = v;
        in_sum    = u[31:0];
        in_cout   = u[32];
        in_a_msb  = a[31];
        in_b_msb  = b[31];
        sat_en    = sat;
        flush     = fl;
        out_ready = ordy;
        e         = mk_entry(a, b, sat);
        m_ready   = (q.size() < 2) && !fl;
        do_push   = v && m_ready;
        do_pop    = (q.size() != 0) && ordy && !fl;
        #1;
        chk({ctx, ".in_ready"}, 32'(in_ready), 32'(m_ready));
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                m_done++;
            end
            if (do_push) begin
                q.push_back(e);
                if (e.ovf && m_ovf < 255) m_ovf++;
            end
        end
        @(negedge clk);
        check_outputs(ctx);
    endtask

    initial begin
        logic [31:0] ra, rb;
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        check_outputs("rst");
        rst_n = 1'b1;

        // small positive sum, one-cycle latency, then pop
        cycle("p5", 1'b1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b1);
        chk("p5.sum", out_sum, 32'd5);
        cycle("p5pop", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("p5.done", 32'(done_cnt), 32'd1);

        // positive overflow, saturated then raw
        cycle("satp", 1'b1, 32'h4000_0000, 32'h4000_0000, 1'b1, 1'b0, 1'b0);
        chk("satp.sum", out_sum, 32'h7FFF_FFFF);
        chk("satp.ovfcnt", 32'(ovf_cnt), 32'd1);
        cycle("satpop", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        cycle("rawp", 1'b1, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        chk("rawp.sum", out_sum, 32'h8000_0000);
        chk("rawp.neg", 32'(out_neg), 32'd1);
        cycle("rawpop", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        // negative overflow saturates to most negative
        cycle("satn", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        chk("satn.sum", out_sum, 32'h8000_0000);
        cycle("satnpop", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        // backpressure: A, B accepted, C held, then drained in order
        cycle("bpA", 1'b1, 32'd10, 32'd1, 1'b0, 1'b0, 1'b0);
        cycle("bpB", 1'b1, 32'd20, 32'd2, 1'b0, 1'b0, 1'b0);
        cycle("bpC0", 1'b1, 32'd30, 32'd3, 1'b0, 1'b0, 1'b0);
        chk("bp.full_sum", out_sum, 32'd11);
        cycle("bpC1", 1'b1, 32'd30, 32'd3, 1'b0, 1'b0, 1'b1);
        cycle("bpC2", 1'b1, 32'd30, 32'd3, 1'b0, 1'b0, 1'b1);
        chk("bp.B_or_C", out_sum, 32'd33);
        // push zero/carry while popping at occupancy 1
        cycle("zc", 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);
        chk("zc.zero", 32'(out_zero), 32'd1);
        chk("zc.cout", 32'(out_cout), 32'd1);
        cycle("zcpop", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        // flush at occupancy 2 with out_ready high drops the pop
        cycle("flA", 1'b1, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle("flB", 1'b1, 32'd8, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle("fl", 1'b1, 32'd9, 32'd0, 1'b0, 1'b1, 1'b1);
        chk("fl.out_valid", 32'(out_valid), 32'd0);

        // ovf_cnt saturation
        for (int i = 0; i < 260; i++)
            cycle("ovfsat", 1'b1, 32'h7000_0000 | 32'($urandom_range(0, 255)),
                  32'h7000_0000, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        chk("ovfsat.cnt", 32'(ovf_cnt), 32'd255);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0 - ra;
            cycle("rnd", 1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
        end

        // asynchronous reset mid-stream at occupancy 2
        cycle("arA", 1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        cycle("arB", 1'b1, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        q.delete();
        m_ovf  = 0;
        m_done = 0;
        chk("ar.in_ready", 32'(in_ready), 32'd0);
        check_outputs("ar");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post", 1'b1, 32'd40, 32'd2, 1'b0, 1'b0, 1'b0);
        chk("post.sum", out_sum, 32'd42);
        cycle("postpop", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
